user_wb_fifo_slave: RTL and testbench



---
 rtl/user_wb_fifo_pkg.sv | 23 ++
 rtl/user_sync_fifo.sv | 63 ++++++
 rtl/user_wb_fifo_slave.sv | 133 +++++++++++++
 tb/tb_user_wb_fifo_slave.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_wb_fifo_pkg.sv
// Shared register map, bit positions and constants for the Wishbone FIFO slave.
package user_wb_fifo_pkg;

  localparam logic [7:0] DATA_OFF   = 8'h00;
  localparam logic [7:0] POP_OFF    = 8'h04;
  localparam logic [7:0] STATUS_OFF = 8'h08;
  localparam logic [7:0] CTRL_OFF   = 8'h0C;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_UDF_BIT   = 3;
  localparam int unsigned ST_IRQ_BIT   = 4;
  localparam int unsigned ST_LEVEL_LSB = 16;
  localparam int unsigned ST_LEVEL_W   = 16;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_THR_LSB = 8;
  localparam int unsigned THR_W        = 8;

  localparam logic [31:0] UNDERFLOW_DATA = 32'h0;

endpackage

// File: rtl/user_sync_fifo.sv
// Single-clock FIFO with combinational head output and an occupancy count.
module user_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            din_i,
  output logic [DW-1:0]            dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push_c, do_pop_c;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Requests against a full/empty FIFO are dropped; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    do_push_c = push_i & ~full_o;
    do_pop_c  = pop_i & ~empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/user_wb_fifo_slave.sv
// Wishbone slave exposing a push/pop FIFO with STATUS/CTRL registers and a fill-level interrupt.
module user_wb_fifo_slave
  import user_wb_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DW       = 32,
  parameter logic [7:0]  BASE_ADR = 8'h30
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  irq
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = (LW > THR_W) ? LW : THR_W;

  logic             hit_c, wr_c, rd_c, push_c, pop_c, pending_c;
  logic [7:0]       off_c;
  logic [31:0]      status_c, ctrl_c;
  logic [DW-1:0]    fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             irq_en_q, irq_en_d, irq_q, irq_d;
  logic [THR_W-1:0] thr_q, thr_d;
  logic             unused_bits_c;

  assign unused_bits_c = ^{wbs_adr_i[23:8], wbs_sel_i[3:2]};

  user_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .din_i   (DW'(wbs_dat_i)),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Decode; the ~ack_q term stops a held strobe from being accepted twice in a row.
  always_comb begin
    off_c     = wbs_adr_i[7:0];
    hit_c     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADR) & ~ack_q;
    wr_c      = hit_c & wbs_we_i;
    rd_c      = hit_c & ~wbs_we_i;
    push_c    = wr_c & (off_c == DATA_OFF);
    pop_c     = rd_c & (off_c == POP_OFF);
    pending_c = (thr_q != '0) && (CW'(fifo_level) >= CW'(thr_q));

    status_c = '0;
    status_c[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
    status_c[ST_IRQ_BIT]   = pending_c;
    status_c[ST_UDF_BIT]   = udf_q;
    status_c[ST_OVF_BIT]   = ovf_q;
    status_c[ST_FULL_BIT]  = fifo_full;
    status_c[ST_EMPTY_BIT] = fifo_empty;

    ctrl_c = '0;
    ctrl_c[CTRL_EN_BIT] = irq_en_q;
    ctrl_c[CTRL_THR_LSB +: THR_W] = thr_q;
  end

  // Next-state for ack, read data, sticky flags, control and interrupt.
  always_comb begin
    ack_d    = hit_c;
    dat_d    = '0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    irq_d    = irq_en_q & pending_c;

    if (rd_c) begin
      case (off_c)
        POP_OFF:    dat_d = fifo_empty ? UNDERFLOW_DATA : 32'(fifo_dout);
        STATUS_OFF: dat_d = status_c;
        CTRL_OFF:   dat_d = ctrl_c;
        default:    dat_d = '0;
      endcase
    end

    if (wr_c && (off_c == STATUS_OFF)) begin
      if (wbs_dat_i[ST_OVF_BIT]) ovf_d = 1'b0;
      if (wbs_dat_i[ST_UDF_BIT]) udf_d = 1'b0;
    end
    // A new event outranks a clear landing in the same cycle.
    if (push_c && fifo_full)  ovf_d = 1'b1;
    if (pop_c && fifo_empty)  udf_d = 1'b1;

    if (wr_c && (off_c == CTRL_OFF)) begin
      if (wbs_sel_i[0]) irq_en_d = wbs_dat_i[CTRL_EN_BIT];
      if (wbs_sel_i[1]) thr_d    = wbs_dat_i[CTRL_THR_LSB +: THR_W];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thr_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
      irq_q    <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = {2'b00, irq_q};

endmodule

// File: tb/tb_user_wb_fifo_slave.sv
// Directed self-checking bench for user_wb_fifo_slave (DEPTH=16, BASE_ADR=8'h30).
module tb_user_wb_fifo_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  irq;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] A_DATA   = 32'h3000_0000;
  localparam logic [31:0] A_POP    = 32'h3000_0004;
  localparam logic [31:0] A_STATUS = 32'h3000_0008;
  localparam logic [31:0] A_CTRL   = 32'h3000_000C;

  user_wb_fifo_slave #(.DEPTH(16), .DW(32), .BASE_ADR(8'h30)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i; rd = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_tests++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL ack_timeout adr=%h got no ack, required ack within 8 cycles", a);
    end
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] rd; int lat;
    wb_access(1'b1, a, d, s, rd, lat);
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
    int lat;
    wb_access(1'b0, a, 32'h0, 4'hF, d, lat);
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({ack, rdat, irq} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs got ack=%b dat=%h irq=%b, required 0/0/0", ack, rdat, irq);
    end
    @(negedge clk); rst_n = 1'b1;
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, d, lat);
    n_tests++;
    if (lat != 1) begin
      n_fail++; $display("FAIL reset_ack_latency got %0d, required 1", lat);
    end
    n_tests++;
    if (d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL reset_status got %h, required 00000001", d);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({ack, rdat, irq} !== 36'h0) begin
      n_fail++; $display("FAIL post_ack_idle got ack=%b dat=%h irq=%b, required 0/0/0", ack, rdat, irq);
    end
  endtask

  task automatic test_fifo_order();
    logic [31:0] d;
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    foreach (vals[i]) wb_wr(A_DATA, vals[i]);
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0003_0000) begin
      n_fail++; $display("FAIL order_status_level3 got %h, required 00030000", d);
    end
    foreach (vals[i]) begin
      wb_rd(A_POP, d);
      n_tests++;
      if (d !== vals[i]) begin
        n_fail++; $display("FAIL order_pop%0d got %h, required %h", i, d, vals[i]);
      end
    end
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL order_status_empty got %h, required 00000001", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) wb_wr(A_DATA, 32'h100 + 32'(i));
    wb_wr(A_DATA, 32'hBAD);
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0010_0006) begin
      n_fail++; $display("FAIL ovf_status got %h, required 00100006", d);
    end
    for (int i = 0; i < 16; i++) begin
      wb_rd(A_POP, d);
      n_tests++;
      if (d !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL ovf_pop%0d got %h, required %h", i, d, 32'h100 + 32'(i));
      end
    end
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0000_0005) begin
      n_fail++; $display("FAIL ovf_status_drained got %h, required 00000005", d);
    end
    wb_wr(A_STATUS, 32'h4);
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL ovf_w1c got %h, required 00000001", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wb_wr(A_CTRL, 32'h0000_0401);
    wb_rd(A_CTRL, d);
    n_tests++;
    if (d !== 32'h0000_0401) begin
      n_fail++; $display("FAIL ctrl_readback got %h, required 00000401", d);
    end
    for (int i = 0; i < 3; i++) wb_wr(A_DATA, 32'hA0 + 32'(i));
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 3'b000) begin
      n_fail++; $display("FAIL irq_below_thr got %b, required 000", irq);
    end
    wb_wr(A_DATA, 32'hA3);
    n_tests++;
    if (irq !== 3'b000) begin
      n_fail++; $display("FAIL irq_at_push_ack got %b, required 000", irq);
    end
    @(posedge clk); #1;
    n_tests++;
    if (irq !== 3'b001) begin
      n_fail++; $display("FAIL irq_at_thr got %b, required 001", irq);
    end
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0004_0010) begin
      n_fail++; $display("FAIL irq_status got %h, required 00040010", d);
    end
    wb_rd(A_POP, d);
    n_tests++;
    if (d !== 32'hA0 || irq !== 3'b001) begin
      n_fail++; $display("FAIL irq_pop_ack got dat=%h irq=%b, required 000000a0/001", d, irq);
    end
    @(posedge clk); #1;
    n_tests++;
    if (irq !== 3'b000) begin
      n_fail++; $display("FAIL irq_after_pop got %b, required 000", irq);
    end
    for (int i = 1; i < 4; i++) begin
      wb_rd(A_POP, d);
      n_tests++;
      if (d !== 32'hA0 + 32'(i)) begin
        n_fail++; $display("FAIL irq_drain%0d got %h, required %h", i, d, 32'hA0 + 32'(i));
      end
    end
    // Only byte 0 enabled: irq_en clears, threshold byte untouched.
    wb_wr(A_CTRL, 32'hFFFF_FF00, 4'b0001);
    wb_rd(A_CTRL, d);
    n_tests++;
    if (d !== 32'h0000_0400) begin
      n_fail++; $display("FAIL ctrl_sel got %h, required 00000400", d);
    end
    wb_wr(A_CTRL, 32'h0000_1101);
    for (int i = 0; i < 16; i++) wb_wr(A_DATA, 32'(i));
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 3'b000) begin
      n_fail++; $display("FAIL irq_thr_gt_depth got %b, required 000", irq);
    end
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0010_0002) begin
      n_fail++; $display("FAIL status_thr_gt_depth got %h, required 00100002", d);
    end
    for (int i = 0; i < 16; i++) wb_rd(A_POP, d);
    wb_wr(A_CTRL, 32'h0);
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    wb_rd(A_POP, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL udf_data got %h, required 00000000", d);
    end
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0000_0009) begin
      n_fail++; $display("FAIL udf_status got %h, required 00000009", d);
    end
    wb_wr(A_STATUS, 32'h8);
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL udf_w1c got %h, required 00000001", d);
    end
    wb_rd(32'h3000_0010, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read got %h, required 00000000", d);
    end
  endtask

  task automatic test_bad_base();
    int acks = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0000; sel = 4'hF;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    n_tests++;
    if (acks != 0) begin
      n_fail++; $display("FAIL bad_base_acks got %0d, required 0", acks);
    end
  endtask

  task automatic test_held_stb();
    logic [31:0] d;
    int acks = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_DATA; wdat = 32'h5A5A_0001; sel = 4'hF;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    n_tests++;
    if (acks != 1) begin
      n_fail++; $display("FAIL held_stb_acks got %0d, required 1", acks);
    end
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0001_0000) begin
      n_fail++; $display("FAIL held_stb_level got %h, required 00010000", d);
    end
    wb_rd(A_POP, d);
    n_tests++;
    if (d !== 32'h5A5A_0001) begin
      n_fail++; $display("FAIL held_stb_data got %h, required 5a5a0001", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) wb_wr(A_DATA, 32'hC0 + 32'(i));
    wb_wr(A_CTRL, 32'h0000_0401);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 3'b001) begin
      n_fail++; $display("FAIL mid_irq_before got %b, required 001", irq);
    end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS; sel = 4'hF;
    @(posedge clk); #1;
    n_tests++;
    if (ack !== 1'b1) begin
      n_fail++; $display("FAIL mid_ack_before got %b, required 1", ack);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ack, rdat, irq} !== 36'h0) begin
      n_fail++; $display("FAIL mid_async_reset got ack=%b dat=%h irq=%b, required 0/0/0", ack, rdat, irq);
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wb_rd(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0000_0001) begin
      n_fail++; $display("FAIL mid_status_after got %h, required 00000001", d);
    end
    wb_rd(A_CTRL, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mid_ctrl_after got %h, required 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_irq();
    test_underflow();
    test_bad_base();
    test_held_stb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
